// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEditH,
    StEditM,
    StEditS,
    StWrH,
    StWrM,
    StWrS
  } state_e;

  // Counter load-port field select, active-low one-hot.
  localparam logic [2:0] ENA_HOUR = 3'b011;
  localparam logic [2:0] ENA_MIN  = 3'b101;
  localparam logic [2:0] ENA_SEC  = 3'b110;
  localparam logic [2:0] ENA_NONE = 3'b111;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

endpackage

// File: rtl/time_set_ctrl_bcd_field_step.sv
// Combinational +/-1 step of a packed-BCD field, wrapping between 00 and max.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       down,
  output logic [7:0] next
);

  always_comb begin
    next = value;
    if (up && !down) begin
      if (value == max) begin
        next = 8'h00;
      end else if (value[3:0] == 4'd9) begin
        next = {value[7:4] + 4'd1, 4'd0};
      end else begin
        next = {value[7:4], value[3:0] + 4'd1};
      end
    end else if (down && !up) begin
      if (value == 8'h00) begin
        next = max;
      end else if (value[3:0] == 4'd0) begin
        next = {value[7:4] - 4'd1, 4'd9};
      end else begin
        next = {value[7:4], value[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven edit session over a BCD copy of h:m:s, committed to the
// counter as three back-to-back load strobes.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic [7:0] set_time,
  output logic [2:0] enable,
  output logic       save,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic [7:0] disp_hour,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic            prev_mode_q, prev_up_q, prev_down_q, prev_set_q;
  logic [7:0]      work_hour_q, work_min_q, work_sec_q;
  logic [CntW-1:0] idle_cnt_q;

  logic       rise_mode, rise_up, rise_down, rise_set, any_rise;
  logic [7:0] step_val, step_max, step_next;

  assign rise_mode = btn_mode & ~prev_mode_q;
  assign rise_up   = btn_up   & ~prev_up_q;
  assign rise_down = btn_down & ~prev_down_q;
  assign rise_set  = btn_set  & ~prev_set_q;
  assign any_rise  = rise_mode | rise_up | rise_down | rise_set;

  always_comb begin
    step_val = work_hour_q;
    step_max = HOUR_MAX;
    case (state_q)
      StEditM: begin
        step_val = work_min_q;
        step_max = MINSEC_MAX;
      end
      StEditS: begin
        step_val = work_sec_q;
        step_max = MINSEC_MAX;
      end
      default: ;
    endcase
  end

  bcd_field_step u_step (
    .value (step_val),
    .max   (step_max),
    .up    (rise_up),
    .down  (rise_down),
    .next  (step_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      prev_mode_q <= 1'b1;
      prev_up_q   <= 1'b1;
      prev_down_q <= 1'b1;
      prev_set_q  <= 1'b1;
      work_hour_q <= 8'h00;
      work_min_q  <= 8'h00;
      work_sec_q  <= 8'h00;
      idle_cnt_q  <= '0;
      save        <= 1'b0;
      enable      <= ENA_NONE;
      set_time    <= 8'h00;
      editing     <= 1'b0;
      edit_field  <= FIELD_NONE;
    end else begin
      prev_mode_q <= btn_mode;
      prev_up_q   <= btn_up;
      prev_down_q <= btn_down;
      prev_set_q  <= btn_set;
      case (state_q)
        StIdle: begin
          if (rise_mode) begin
            state_q     <= StEditH;
            work_hour_q <= cur_hour;
            work_min_q  <= cur_min;
            work_sec_q  <= cur_sec;
            idle_cnt_q  <= '0;
            editing     <= 1'b1;
            edit_field  <= FIELD_HOUR;
          end
        end
        StEditH, StEditM, StEditS: begin
          if (rise_set) begin
            // Commit wins over any other edge in the same cycle.
            state_q    <= StWrH;
            idle_cnt_q <= '0;
            save       <= 1'b1;
            enable     <= ENA_HOUR;
            set_time   <= work_hour_q;
            editing    <= 1'b0;
            edit_field <= FIELD_NONE;
          end else if (any_rise) begin
            idle_cnt_q <= '0;
            if (rise_up || rise_down) begin
              case (state_q)
                StEditH: work_hour_q <= step_next;
                StEditM: work_min_q  <= step_next;
                default: work_sec_q  <= step_next;
              endcase
            end
            if (rise_mode) begin
              case (state_q)
                StEditH: begin
                  state_q    <= StEditM;
                  edit_field <= FIELD_MIN;
                end
                StEditM: begin
                  state_q    <= StEditS;
                  edit_field <= FIELD_SEC;
                end
                default: begin
                  state_q    <= StEditH;
                  edit_field <= FIELD_HOUR;
                end
              endcase
            end
          end else if (idle_cnt_q == CntLast) begin
            state_q    <= StIdle;
            idle_cnt_q <= '0;
            editing    <= 1'b0;
            edit_field <= FIELD_NONE;
          end else begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
          end
        end
        StWrH: begin
          state_q  <= StWrM;
          enable   <= ENA_MIN;
          set_time <= work_min_q;
        end
        StWrM: begin
          state_q  <= StWrS;
          enable   <= ENA_SEC;
          set_time <= work_sec_q;
        end
        StWrS: begin
          state_q  <= StIdle;
          save     <= 1'b0;
          enable   <= ENA_NONE;
          set_time <= 8'h00;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    if (state_q == StIdle) begin
      disp_hour = cur_hour;
      disp_min  = cur_min;
      disp_sec  = cur_sec;
    end else begin
      disp_hour = work_hour_q;
      disp_min  = work_min_q;
      disp_sec  = work_sec_q;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with a short timeout.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down, btn_set;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic [7:0] set_time;
  logic [2:0] enable;
  logic       save, editing;
  logic [1:0] edit_field;
  logic [7:0] disp_hour, disp_min, disp_sec;

  int checks = 0;
  int failures = 0;

  time_set_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_set    (btn_set),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_time   (set_time),
    .enable     (enable),
    .save       (save),
    .editing    (editing),
    .edit_field (edit_field),
    .disp_hour  (disp_hour),
    .disp_min   (disp_min),
    .disp_sec   (disp_sec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse one button for one edge, then release it for one edge.
  task automatic press(input logic [3:0] m);
    {btn_mode, btn_up, btn_down, btn_set} = m;
    tick();
    {btn_mode, btn_up, btn_down, btn_set} = 4'b0000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {btn_mode, btn_up, btn_down, btn_set} = 4'b1000;
    cur_hour = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
    tick(); tick();
    chk("rst_save", save, 1'b0);
    chk("rst_enable", enable, 3'b111);
    chk("rst_set_time", set_time, 8'h00);
    chk("rst_editing", editing, 1'b0);
    chk("rst_field", edit_field, 2'd0);
    chk("rst_disp_hour", disp_hour, 8'h12);

    // Mode held through reset must not count as an edge.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_editing", editing, 1'b0);
      chk("held_save", save, 1'b0);
    end
    btn_mode = 1'b0;
    tick();

    // Enter edit, capture 12:34:56.
    btn_mode = 1'b1;
    tick();
    chk("enter_editing", editing, 1'b1);
    chk("enter_field", edit_field, 2'd1);
    chk("enter_work", {disp_hour, disp_min, disp_sec}, 24'h123456);
    btn_mode = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) press(4'b0100);
    chk("hour_23", disp_hour, 8'h23);
    btn_up = 1'b1;
    tick();
    chk("hour_wrap_00", disp_hour, 8'h00);
    btn_up = 1'b0;
    tick();

    // Commit: three save cycles hour/min/sec.
    btn_set = 1'b1;
    tick();
    chk("wr_h_save", save, 1'b1);
    chk("wr_h_enable", enable, 3'b011);
    chk("wr_h_data", set_time, 8'h00);
    chk("wr_h_editing", editing, 1'b0);
    chk("wr_h_disp", disp_hour, 8'h00);
    btn_set = 1'b0;
    tick();
    chk("wr_m_save", save, 1'b1);
    chk("wr_m_enable", enable, 3'b101);
    chk("wr_m_data", set_time, 8'h34);
    tick();
    chk("wr_s_save", save, 1'b1);
    chk("wr_s_enable", enable, 3'b110);
    chk("wr_s_data", set_time, 8'h56);
    tick();
    chk("wr_done_save", save, 1'b0);
    chk("wr_done_enable", enable, 3'b111);
    chk("wr_done_set_time", set_time, 8'h00);
    chk("wr_done_disp", disp_hour, 8'h12);

    // Minute field wrap and BCD carry.
    cur_min = 8'h00;
    press(4'b1000);
    press(4'b1000);
    chk("edit_m_field", edit_field, 2'd2);
    btn_down = 1'b1;
    tick();
    chk("min_down_wrap", disp_min, 8'h59);
    btn_down = 1'b0;
    tick();
    press(4'b0100);
    chk("min_up_wrap", disp_min, 8'h00);
    for (int i = 0; i < 9; i++) press(4'b0100);
    chk("min_09", disp_min, 8'h09);
    press(4'b0100);
    chk("min_carry_10", disp_min, 8'h10);

    // Up+down together: no step, but restarts the timeout.
    {btn_up, btn_down} = 2'b11;
    tick();
    chk("updown_hold", disp_min, 8'h10);
    {btn_up, btn_down} = 2'b00;
    tick(); tick(); tick();
    chk("timeout_not_yet", editing, 1'b1);
    tick();
    chk("timeout_fired", editing, 1'b0);
    chk("timeout_field", edit_field, 2'd0);
    chk("timeout_no_save", save, 1'b0);
    chk("timeout_disp", disp_min, 8'h00);

    // Set+mode together in EDIT_S goes to write, not EDIT_H.
    cur_min = 8'h34;
    press(4'b1000);
    press(4'b1000);
    press(4'b1000);
    chk("edit_s_field", edit_field, 2'd3);
    {btn_mode, btn_set} = 2'b11;
    tick();
    chk("setmode_save", save, 1'b1);
    chk("setmode_enable", enable, 3'b011);
    chk("setmode_data", set_time, 8'h12);
    chk("setmode_field", edit_field, 2'd0);
    {btn_mode, btn_set} = 2'b00;
    tick(); tick(); tick();
    chk("setmode_done", save, 1'b0);

    // Set on the third idle cycle still commits; then reset in WR_M.
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick(); tick();
    btn_set = 1'b1;
    tick();
    chk("late_set_save", save, 1'b1);
    chk("late_set_enable", enable, 3'b011);
    btn_set = 1'b0;
    tick();
    chk("late_wr_m_enable", enable, 3'b101);
    reset = 1'b1;
    #1;
    chk("abort_save", save, 1'b0);
    chk("abort_enable", enable, 3'b111);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_idle_save", save, 1'b0);
    chk("abort_idle_field", edit_field, 2'd0);
    chk("abort_idle_disp", disp_hour, 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
